network_sel_ctrl: RTL and testbench

Stage sequencer for the butterfly output crossbar of the 512-point NTT/INTT core. On a start pulse it runs a fixed number of butterfly stages of 128 cycles each. Every cycle it drives the four 2-bit crossbar select codes and a valid flag. Between stages it inserts a drain gap equal to the butterfly pipeline latency of the active mode, and it ends the transform with a one-cycle done pulse. It sits between the top-level core control and the output routing network.

---
 rtl/network_sel_ctrl.sv | 147 ++++++++++++++
 tb/tb_network_sel_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/network_sel_ctrl.sv
// Stage sequencer for the NTT/INTT butterfly output crossbar: runs NUM_STAGE
// stages of CYC_PER_STAGE cycles, separated by a mode-dependent drain gap.
module network_sel_ctrl #(
   parameter int NUM_STAGE     = 5,
   parameter int CYC_PER_STAGE = 128,
   parameter int LAT_NTT       = 7,
   parameter int LAT_INTT      = 13
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       sel,
   output logic       sel_out,
   output logic       busy,
   output logic       done,
   output logic       valid,
   output logic [3:0] stage,
   output logic [1:0] sel_a_0,
   output logic [1:0] sel_a_1,
   output logic [1:0] sel_a_2,
   output logic [1:0] sel_a_3,
   output logic [1:0] o_dbg_state
);

   localparam int CYC_W = $clog2(CYC_PER_STAGE);
   localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(CYC_PER_STAGE - 1);
   localparam logic [3:0]       STAGE_LAST = 4'(NUM_STAGE - 1);
   localparam logic [3:0]       GAP_NTT    = 4'(LAT_NTT - 1);
   localparam logic [3:0]       GAP_INTT   = 4'(LAT_INTT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t           r_state;
   logic [CYC_W-1:0] r_cyc;
   logic [3:0]       r_gap;
   logic [3:0]       r_stage;
   logic             r_sel_out;
   logic             r_busy;
   logic             r_done;
   logic             r_valid;
   logic [7:0]       r_codes;

   state_t           w_state_nxt;
   logic [CYC_W-1:0] w_cyc_nxt;
   logic [3:0]       w_gap_nxt;
   logic [3:0]       w_stage_nxt;
   logic             w_sel_out_nxt;
   logic [7:0]       w_codes_nxt;

   always_comb begin
      w_state_nxt   = r_state;
      w_cyc_nxt     = r_cyc;
      w_gap_nxt     = r_gap;
      w_stage_nxt   = r_stage;
      w_sel_out_nxt = r_sel_out;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state_nxt   = S_RUN;
               w_sel_out_nxt = sel;
               w_stage_nxt   = 4'd0;
               w_cyc_nxt     = '0;
            end
         end
         S_RUN: begin
            w_cyc_nxt = r_cyc + 1'b1;
            if (r_cyc == CYC_LAST) begin
               w_state_nxt = S_DRAIN;
               w_cyc_nxt   = '0;
               w_gap_nxt   = r_sel_out ? GAP_INTT : GAP_NTT;
            end
         end
         S_DRAIN: begin
            if (r_gap == 4'd0) begin
               if (r_stage == STAGE_LAST) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_RUN;
                  w_stage_nxt = r_stage + 4'd1;
                  w_cyc_nxt   = '0;
               end
            end else begin
               w_gap_nxt = r_gap - 4'd1;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Codes are decoded from the next-state counters so the outputs are flops.
   always_comb begin
      w_codes_nxt = 8'h00;
      if (w_state_nxt == S_RUN) begin
         if (w_stage_nxt[0] && !w_cyc_nxt[0]) begin
            w_codes_nxt = {2'b01, 2'b11, 2'b00, 2'b10};
         end else begin
            w_codes_nxt = {2'b01, 2'b00, 2'b11, 2'b10};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cyc     <= '0;
         r_gap     <= 4'd0;
         r_stage   <= 4'd0;
         r_sel_out <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_valid   <= 1'b0;
         r_codes   <= 8'h00;
      end else begin
         r_state   <= w_state_nxt;
         r_cyc     <= w_cyc_nxt;
         r_gap     <= w_gap_nxt;
         r_stage   <= w_stage_nxt;
         r_sel_out <= w_sel_out_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
         r_done    <= (w_state_nxt == S_DONE);
         r_valid   <= (w_state_nxt == S_RUN);
         r_codes   <= w_codes_nxt;
      end
   end

   assign sel_out     = r_sel_out;
   assign busy        = r_busy;
   assign done        = r_done;
   assign valid       = r_valid;
   assign stage       = r_stage;
   assign sel_a_0     = r_codes[7:6];
   assign sel_a_1     = r_codes[5:4];
   assign sel_a_2     = r_codes[3:2];
   assign sel_a_3     = r_codes[1:0];
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_network_sel_ctrl.sv
// Scoreboard bench for network_sel_ctrl: the driver queues every expected
// valid/done cycle; a negedge monitor pops and compares as the DUT presents them.
module tb_network_sel_ctrl;

   localparam int NUM = 5;
   localparam int CPS = 128;
   localparam int LN  = 7;
   localparam int LI  = 13;
   localparam int W   = 35;
   localparam int unsigned NO_CUT = 32'hFFFF_FFFF;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       sel;
   logic       sel_out;
   logic       busy;
   logic       done;
   logic       valid;
   logic [3:0] stage;
   logic [1:0] sel_a_0, sel_a_1, sel_a_2, sel_a_3;
   logic [1:0] o_dbg_state;

   network_sel_ctrl #(
      .NUM_STAGE(NUM), .CYC_PER_STAGE(CPS), .LAT_NTT(LN), .LAT_INTT(LI)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .sel(sel),
      .sel_out(sel_out), .busy(busy), .done(done), .valid(valid),
      .stage(stage), .sel_a_0(sel_a_0), .sel_a_1(sel_a_1),
      .sel_a_2(sel_a_2), .sel_a_3(sel_a_3), .o_dbg_state(o_dbg_state)
   );

   always #5 clk = ~clk;

   int unsigned cyc_cnt = 0;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   logic [W-1:0] exp_q[$];
   int errors = 0;
   int checks = 0;

   // Entry layout: {is_done, cycle[19:0], stage, codes d0..d3, sel_out, busy}
   function automatic logic [W-1:0] pack(bit kind, int unsigned t, logic [3:0] st,
                                         logic [7:0] codes, bit so, bit bz);
      logic [19:0] t20;
      t20 = t[19:0];
      return {kind, t20, st, codes, so, bz};
   endfunction

   // Expected trace from the timing formula; entries at or after 'cut' are dropped.
   task automatic push_xfer(int unsigned t0, bit s, int unsigned cut);
      int unsigned p;
      int unsigned tm;
      logic [7:0] codes;
      p = CPS + (s ? LI : LN);
      for (int k = 0; k < NUM; k++) begin
         for (int c = 0; c < CPS; c++) begin
            tm = t0 + 1 + k * p + c;
            codes = ((k % 2 == 1) && (c % 2 == 0)) ? 8'h72 : 8'h4E;
            if (tm < cut) exp_q.push_back(pack(1'b0, tm, 4'(k), codes, s, 1'b1));
         end
      end
      tm = t0 + 1 + NUM * p;
      if (tm < cut) exp_q.push_back(pack(1'b1, tm, 4'(NUM - 1), 8'h00, s, 1'b1));
   endtask

   always @(negedge clk) begin
      logic [W-1:0] act;
      logic [W-1:0] e;
      if (!rst) begin
         if (valid || done) begin
            act = pack(done, cyc_cnt, stage, {sel_a_0, sel_a_1, sel_a_2, sel_a_3}, sel_out, busy);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output got=%h at cycle %0d, required no output", act, cyc_cnt);
            end else begin
               e = exp_q.pop_front();
               if (act !== e) begin
                  errors++;
                  $display("FAIL trace got=%h required=%h (cycle %0d)", act, e, cyc_cnt);
               end
            end
         end else begin
            checks++;
            if ({sel_a_0, sel_a_1, sel_a_2, sel_a_3} !== 8'h00) begin
               errors++;
               $display("FAIL idle_codes got=%h required=00 (cycle %0d)",
                        {sel_a_0, sel_a_1, sel_a_2, sel_a_3}, cyc_cnt);
            end
         end
      end
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s got=%h required=%h (cycle %0d)", name, act, req, cyc_cnt);
      end
   endtask

   task automatic tick(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic goto_cycle(int unsigned x);
      while (cyc_cnt < x) tick(1);
   endtask

   task automatic start_xfer(bit s, output int unsigned t0);
      start = 1'b1;
      sel   = s;
      t0    = cyc_cnt;
      push_xfer(t0, s, NO_CUT);
      tick(1);
      start = 1'b0;
   endtask

   task automatic check_reset_outs(string name);
      @(negedge clk);
      check(name, {busy, done, valid, sel_out, stage, sel_a_0, sel_a_1, sel_a_2, sel_a_3, o_dbg_state},
            32'h0);
      tick(1);
   endtask

   task automatic check_idle_after(string name);
      @(negedge clk);
      check({name, "_busy"}, {31'd0, busy}, 32'd0);
      check({name, "_drained"}, exp_q.size(), 32'd0);
      tick(1);
   endtask

   initial begin
      int unsigned t0;
      int unsigned t1;
      int unsigned rc;
      rst   = 1'b1;
      start = 1'b0;
      sel   = 1'b0;
      tick(2);
      check_reset_outs("reset_values");
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", {30'd0, o_dbg_state}, 32'd0);
      tick(1);

      // NTT transform, done expected at T+676
      start_xfer(1'b0, t0);
      goto_cycle(t0 + 677);
      check_idle_after("ntt");

      // INTT transform with ignored start/sel during stage 2 and start in DONE
      start_xfer(1'b1, t0);
      goto_cycle(t0 + 1 + 2 * 141 + 20);
      start = 1'b1;
      sel   = 1'b0;
      tick(1);
      start = 1'b0;
      sel   = 1'b1;
      tick(3);
      sel   = 1'b0;
      goto_cycle(t0 + 706);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(2);
      check_idle_after("intt");

      // Reset in the drain of stage 3, then a full clean transform
      start = 1'b1;
      sel   = 1'b0;
      t0    = cyc_cnt;
      rc    = t0 + 1 + 3 * 135 + 128 + 3;
      push_xfer(t0, 1'b0, rc);
      tick(1);
      start = 1'b0;
      goto_cycle(rc);
      rst = 1'b1;
      check_reset_outs("reset_mid_drain");
      check("reset_trace_drained", exp_q.size(), 32'd0);
      tick(2);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_mid_reset", {30'd0, o_dbg_state}, 32'd0);
      tick(1);
      start_xfer(1'b0, t0);
      goto_cycle(t0 + 677);
      check_idle_after("post_reset");

      // start held high: second transform accepted in the IDLE cycle after DONE
      start = 1'b1;
      sel   = 1'b0;
      t1    = cyc_cnt;
      push_xfer(t1, 1'b0, NO_CUT);
      push_xfer(t1 + 677, 1'b0, NO_CUT);
      goto_cycle(t1 + 677 + 676);
      start = 1'b0;
      goto_cycle(t1 + 677 + 678);
      check_idle_after("held_start");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
